// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing generator with pixel request and RGB capture
module vga_timing_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_VALID  = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_VALID  = 480,
  parameter int V_FRONT  = 10,
  parameter int SYNC_POL = 0
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_req,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  // All window decodes are done on 10-bit unsigned values.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] REQ_H_LO = 10'(HA - 1);
  localparam logic [9:0] REQ_H_HI = 10'(HA + H_VALID - 2);
  localparam logic [9:0] DSP_H_LO = 10'(HA);
  localparam logic [9:0] DSP_H_HI = 10'(HA + H_VALID - 1);
  localparam logic [9:0] V_LO     = 10'(VA);
  localparam logic [9:0] V_HI     = 10'(VA + V_VALID - 1);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       running;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       v_act_nxt;
  logic       req_nxt;
  logic       dsp_nxt;

  // Next raster position; the first clock after reset holds (0,0) so that
  // position is presented for a full cycle together with frame_start.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (!running) begin
      h_nxt = 10'd0;
      v_nxt = 10'd0;
    end else if (h_cnt == H_LAST) begin
      h_nxt = 10'd0;
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_nxt = h_cnt + 10'd1;
    end
  end

  // Window decodes on the next position so registered outputs line up with the counters.
  always_comb begin
    v_act_nxt = (v_nxt >= V_LO) && (v_nxt <= V_HI);
    req_nxt   = v_act_nxt && (h_nxt >= REQ_H_LO) && (h_nxt <= REQ_H_HI);
    dsp_nxt   = v_act_nxt && (h_nxt >= DSP_H_LO) && (h_nxt <= DSP_H_HI);
  end

  // Counters plus every registered timing output.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      running     <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      pix_req     <= 1'b0;
      pix_x       <= 10'h3FF;
      pix_y       <= 10'h3FF;
      rgb_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      running     <= 1'b1;
      hsync       <= (h_nxt < H_SYNC_W) ? SYNC_ON : ~SYNC_ON;
      vsync       <= (v_nxt < V_SYNC_W) ? SYNC_ON : ~SYNC_ON;
      pix_req     <= req_nxt;
      pix_x       <= req_nxt ? (h_nxt - REQ_H_LO) : 10'h3FF;
      pix_y       <= req_nxt ? (v_nxt - V_LO) : 10'h3FF;
      rgb_valid   <= dsp_nxt;
      line_start  <= (h_nxt == 10'd0);
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

  // The renderer already registered pix_data one clock after the request, so
  // it is gated straight through; blanking forces zero regardless of pix_data.
  always_comb begin
    rgb = rgb_valid ? pix_data : 16'h0000;
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - bench for vga_timing_ctrl
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       rv;
    logic       ls;
    logic       fs;
  } exp_t;

  typedef struct {
    int   k;
    exp_t e;
  } vec_t;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic        sys_rst;
  logic [15:0] d_pix, s_pix;
  logic [9:0]  d_x, d_y, s_x, s_y;
  logic        d_req, d_hs, d_vs, d_rv, d_ls, d_fs;
  logic        s_req, s_hs, s_vs, s_rv, s_ls, s_fs;
  logic [15:0] d_rgb, s_rgb;

  int total = 0;
  int bad = 0;
  int k = 0;
  bit running = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int hs_cnt = 0, vs_cnt = 0, ls_cnt = 0, fs_cnt = 0;
  vec_t tab[12];

  vga_timing_ctrl u_dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_data(d_pix),
    .pix_x(d_x), .pix_y(d_y), .pix_req(d_req), .hsync(d_hs), .vsync(d_vs),
    .rgb(d_rgb), .rgb_valid(d_rv), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_ctrl #(
    .H_SYNC(1), .H_BACK(1), .H_VALID(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_VALID(3), .V_FRONT(1), .SYNC_POL(0)
  ) u_small (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_data(s_pix),
    .pix_x(s_x), .pix_y(s_y), .pix_req(s_req), .hsync(s_hs), .vsync(s_vs),
    .rgb(s_rgb), .rgb_valid(s_rv), .line_start(s_ls), .frame_start(s_fs)
  );

  // Loopback renderers: register {pix_y[5:0], pix_x}, junk outside requests.
  always @(posedge vga_clk) begin
    d_pix <= d_req ? {d_y[5:0], d_x} : 16'hBEEF;
    s_pix <= s_req ? {s_y[5:0], s_x} : 16'hBEEF;
  end

  function automatic exp_t mk(input logic req, input logic [9:0] x, input logic [9:0] y,
                              input logic hs, input logic vs, input logic rv,
                              input logic ls, input logic fs);
    exp_t e;
    e.req = req; e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.rv = rv; e.ls = ls; e.fs = fs;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    return mk(1'b0, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  // Raster position derived from cycles since reset release.
  function automatic exp_t model(input int kk, input int hsw, input int hb, input int hv, input int hf,
                                 input int vsw, input int vb, input int vv, input int vf);
    int ht, vt, h, v, ha, va;
    bit vline, req, rv;
    ht = hsw + hb + hv + hf;
    vt = vsw + vb + vv + vf;
    h = kk % ht;
    v = (kk / ht) % vt;
    ha = hsw + hb;
    va = vsw + vb;
    vline = (v >= va) && (v < va + vv);
    req = vline && (h >= ha - 1) && (h <= ha + hv - 2);
    rv = vline && (h >= ha) && (h <= ha + hv - 1);
    return mk(req, req ? 10'(h - (ha - 1)) : 10'h3FF, req ? 10'(v - va) : 10'h3FF,
              (h < hsw) ? 1'b0 : 1'b1, (v < vsw) ? 1'b0 : 1'b1, rv, h == 0, (h == 0) && (v == 0));
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, got, want);
    end
  endtask

  task automatic sb(input int idx, input exp_t e, input logic [15:0] rgb_got);
    logic [15:0] w;
    if (e.rv) begin
      if ((idx == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL sb_empty inst=%0d k=%0d got=%h want=queued", idx, k, rgb_got);
      end else begin
        w = (idx == 0) ? q0.pop_front() : q1.pop_front();
        chk(idx == 0 ? "rgb_d" : "rgb_s", 32'(rgb_got), 32'(w));
      end
    end else begin
      chk(idx == 0 ? "blank_d" : "blank_s", 32'(rgb_got), 32'h0);
    end
    if (e.req) begin
      if (idx == 0) q0.push_back({e.y[5:0], e.x});
      else q1.push_back({e.y[5:0], e.x});
    end
  endtask

  task automatic step();
    exp_t ed, es;
    @(posedge vga_clk);
    #1;
    if (sys_rst) running = 0;
    else if (running) k++;
    else begin
      running = 1;
      k = 0;
    end
    ed = running ? model(k, 96, 48, 640, 16, 2, 33, 480, 10) : rst_exp();
    es = running ? model(k, 1, 1, 4, 1, 1, 1, 3, 1) : rst_exp();
    chk("out_d", 32'({d_req, d_x, d_y, d_hs, d_vs, d_rv, d_ls, d_fs}), 32'(ed));
    chk("out_s", 32'({s_req, s_x, s_y, s_hs, s_vs, s_rv, s_ls, s_fs}), 32'(es));
    sb(0, ed, d_rgb);
    sb(1, es, s_rgb);
    if (running) begin
      if (k < 800 && d_hs == 1'b0) hs_cnt++;
      if (k < 2400 && d_vs == 1'b0) vs_cnt++;
      if (k < 1600 && d_ls) ls_cnt++;
      if (k < 126 && s_fs) fs_cnt++;
    end
  endtask

  initial begin
    int guard;
    tab[0]  = '{0,     mk(1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)};
    tab[1]  = '{95,    mk(1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tab[2]  = '{96,    mk(1'b0, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
    tab[3]  = '{800,   mk(1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
    tab[4]  = '{1600,  mk(1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)};
    tab[5]  = '{27343, mk(1'b0, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    tab[6]  = '{28143, mk(1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    tab[7]  = '{28144, mk(1'b1, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    tab[8]  = '{28782, mk(1'b1, 10'd639, 10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    tab[9]  = '{28783, mk(1'b0, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    tab[10] = '{28784, mk(1'b0, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    tab[11] = '{28943, mk(1'b1, 10'd0,   10'd1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};

    sys_rst = 1'b1;
    repeat (3) step();
    @(negedge vga_clk);
    sys_rst = 1'b0;
    step();

    foreach (tab[i]) begin
      guard = 0;
      while (k < tab[i].k && guard < 40000) begin
        step();
        guard++;
      end
      chk("vec", 32'({d_req, d_x, d_y, d_hs, d_vs, d_rv, d_ls, d_fs}), 32'(tab[i].e));
    end

    chk("hsync_active_clks", 32'(hs_cnt), 32'd96);
    chk("vsync_active_clks", 32'(vs_cnt), 32'd1600);
    chk("line_start_count", 32'(ls_cnt), 32'd2);
    chk("small_frame_starts", 32'(fs_cnt), 32'd3);

    // Reset mid active line: outputs must drop in the same cycle.
    while (k < 29200) step();
    #1;
    sys_rst = 1'b1;
    #1;
    chk("rst_async_out", 32'({d_req, d_x, d_y, d_hs, d_vs, d_rv, d_ls, d_fs}), 32'(rst_exp()));
    chk("rst_async_rgb", 32'(d_rgb), 32'h0);
    chk("rst_async_small", 32'({s_req, s_x, s_y, s_hs, s_vs, s_rv, s_ls, s_fs}), 32'(rst_exp()));
    q0.delete();
    q1.delete();
    repeat (3) step();
    @(negedge vga_clk);
    sys_rst = 1'b0;
    step();
    chk("restart_frame_start", 32'(d_fs), 32'h1);
    chk("restart_hsync", 32'(d_hs), 32'h0);
    repeat (300) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
